// File: rtl/led_matrix_pwm_scanner_if.sv
// Signal bundle between the pixel-generating logic (master) and the LED scan driver (slave).
// LoadReq/LoadAck: LoadReq may be held or pulsed on any cycle and is remembered until
// the next frame boundary, where PixelIn is captured and LoadAck pulses for one cycle.
interface led_matrix_pwm_scanner_if #(
   parameter int ROWS     = 16,
   parameter int COLS     = 16,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4
);
   localparam int RW = $clog2(ROWS);

   logic                               EnableCount;
   logic [CHANNELS*ROWS*COLS*DEPTH-1:0] PixelIn;
   logic                               LoadReq;
   logic                               LoadAck;
   logic                               FrameStart;
   logic [RW-1:0]                      RowSelect;
   logic                               Blank;
   logic [CHANNELS*COLS-1:0]           ColDrive;
   logic                               ScanOn;   // debug view of the row FSM (1 = ON phase)

   modport master (
      output EnableCount, PixelIn, LoadReq,
      input  LoadAck, FrameStart, RowSelect, Blank, ColDrive, ScanOn
   );

   modport slave (
      input  EnableCount, PixelIn, LoadReq,
      output LoadAck, FrameStart, RowSelect, Blank, ColDrive, ScanOn
   );
endinterface

// File: rtl/led_matrix_pwm_scanner.sv
// Row-scanned LED matrix driver with per-pixel PWM, inter-row blanking and a
// shadow frame buffer that is only refreshed at the frame boundary.
module led_matrix_pwm_scanner #(
   parameter int ROWS     = 16,
   parameter int COLS     = 16,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4,
   parameter int FREQDIV  = 0,
   parameter int BLANK    = 1
) (
   input logic                    CLK,
   input logic                    RST,
   led_matrix_pwm_scanner_if.slave bus
);
   localparam int RW   = $clog2(ROWS);
   localparam int PW   = (FREQDIV > 0) ? FREQDIV : 1;
   localparam int SW   = (DEPTH > $clog2(BLANK + 1)) ? DEPTH : $clog2(BLANK + 1);
   localparam int NPIX = CHANNELS * ROWS * COLS * DEPTH;

   localparam logic [PW-1:0] PRESC_LAST = PW'((1 << FREQDIV) - 1);
   localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK - 1);
   localparam logic [SW-1:0] ON_LAST    = SW'((1 << DEPTH) - 2);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [SW-1:0]       slot_q, slot_d;
   logic [RW-1:0]       row_q, row_d;
   logic [NPIX-1:0]     shadow_q, shadow_d;
   logic                pending_q, pending_d;
   logic                load_ack_q, frame_start_q;
   logic                tick, wrap, capture;
   logic [CHANNELS*COLS-1:0] col_drive;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_BLANK;
         presc_q       <= '0;
         slot_q        <= '0;
         row_q         <= '0;
         shadow_q      <= '0;
         pending_q     <= 1'b0;
         load_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         slot_q        <= slot_d;
         row_q         <= row_d;
         shadow_q      <= shadow_d;
         pending_q     <= pending_d;
         load_ack_q    <= capture;
         frame_start_q <= wrap;
      end
   end

   always_comb begin
      presc_d = presc_q;
      state_d = state_q;
      slot_d  = slot_q;
      row_d   = row_q;
      tick    = 1'b0;
      wrap    = 1'b0;
      if (bus.EnableCount) begin
         if (presc_q == PRESC_LAST) begin
            tick    = 1'b1;
            presc_d = '0;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
      if (tick) begin
         case (state_q)
            ST_BLANK: begin
               if (slot_q == BLANK_LAST) begin
                  state_d = ST_ON;
                  slot_d  = '0;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end
            default: begin
               if (slot_q == ON_LAST) begin
                  state_d = ST_BLANK;
                  slot_d  = '0;
                  wrap    = (row_q == ROW_LAST);
                  row_d   = wrap ? '0 : row_q + 1'b1;
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end
         endcase
      end
      // A request seen in the wrap cycle itself is served there rather than re-pended.
      capture   = wrap && (pending_q || bus.LoadReq);
      pending_d = wrap ? 1'b0 : (pending_q || bus.LoadReq);
      shadow_d  = capture ? bus.PixelIn : shadow_q;
   end

   always_comb begin
      col_drive = '0;
      if (state_q == ST_ON) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int col = 0; col < COLS; col++) begin
               col_drive[ch*COLS + (COLS-1-col)] =
                  SW'(shadow_q[((ch*ROWS + int'(row_q))*COLS + col)*DEPTH +: DEPTH]) > slot_q;
            end
         end
      end
   end

   assign bus.RowSelect  = row_q;
   assign bus.Blank      = (state_q == ST_BLANK);
   assign bus.ColDrive   = col_drive;
   assign bus.LoadAck    = load_ack_q;
   assign bus.FrameStart = frame_start_q;
   assign bus.ScanOn     = (state_q == ST_ON);
endmodule

// File: tb/tb_led_matrix_pwm_scanner.sv
// Bench for the LED scan driver: default configuration plus a small FREQDIV/BLANK variant,
// both compared every cycle against a tick-count model of the scan and frame buffer.
module tb_led_matrix_pwm_scanner;
   localparam int R = 16, C = 16, CH = 2, D = 4, BL = 1, P = 1;
   localparam int L = (1 << D) - 1;
   localparam int F = R * (BL + L);
   localparam int R2 = 8, C2 = 4, CH2 = 3, D2 = 2, BL2 = 2, P2 = 4;
   localparam int L2 = (1 << D2) - 1;
   localparam int F2 = R2 * (BL2 + L2);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0;
   logic load_req = 1'b0;

   int errors = 0;
   int checks = 0;

   int pix[CH][R][C];
   int sh[CH][R][C];
   int en_cnt = 0;
   int cyc = 0;
   logic last_en = 1'b0;
   logic pend = 1'b0;
   logic [31:0] exp_q[$];

   led_matrix_pwm_scanner_if #(.ROWS(R), .COLS(C), .CHANNELS(CH), .DEPTH(D)) bus1 ();
   led_matrix_pwm_scanner_if #(.ROWS(R2), .COLS(C2), .CHANNELS(CH2), .DEPTH(D2)) bus2 ();

   led_matrix_pwm_scanner #(.ROWS(R), .COLS(C), .CHANNELS(CH), .DEPTH(D), .FREQDIV(0), .BLANK(BL))
      dut (.CLK(clk), .RST(rst), .bus(bus1));
   led_matrix_pwm_scanner #(.ROWS(R2), .COLS(C2), .CHANNELS(CH2), .DEPTH(D2), .FREQDIV(2), .BLANK(BL2))
      dut2 (.CLK(clk), .RST(rst), .bus(bus2));

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // driver tasks
   function automatic logic [CH*R*C*D-1:0] pack_pix();
      logic [CH*R*C*D-1:0] v = '0;
      logic [31:0] w;
      for (int ch = 0; ch < CH; ch++)
         for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
               w = pix[ch][r][c];
               v[((ch*R + r)*C + c)*D +: D] = w[D-1:0];
            end
      return v;
   endfunction

   task automatic set_en(input logic v);
      en = v;
      bus1.EnableCount = v;
      bus2.EnableCount = v;
   endtask

   task automatic set_req(input logic v);
      load_req = v;
      bus1.LoadReq = v;
   endtask

   task automatic drive_pix();
      bus1.PixelIn = pack_pix();
   endtask

   task automatic rand_pix();
      for (int ch = 0; ch < CH; ch++)
         for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
               case ($urandom_range(0, 3))
                  0: pix[ch][r][c] = 0;
                  1: pix[ch][r][c] = L;
                  default: pix[ch][r][c] = $urandom_range(0, L);
               endcase
      drive_pix();
   endtask

   task automatic count_acks(input int ncyc, output int acks);
      acks = 0;
      for (int i = 0; i < ncyc; i++) begin
         if (bus1.LoadAck) acks++;
         @(negedge clk);
      end
   endtask

   task automatic wait_fs(input string tag, input int limit);
      int n = 0;
      while (!bus1.FrameStart && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 64'(bus1.FrameStart), 64'(1));
   endtask

   // reference model: scan position follows from the count of enabled clocks
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         en_cnt  <= 0;
         cyc     <= 0;
         last_en <= 1'b0;
         pend    <= 1'b0;
         exp_q.delete();
         foreach (sh[a, b, c]) sh[a][b][c] <= 0;
      end else begin
         cyc     <= cyc + 1;
         last_en <= en;
         if (en) en_cnt <= en_cnt + 1;
         if (en && ((en_cnt + 1) % (P * F) == 0)) begin
            if (pend || load_req) begin
               sh <= pix;
               exp_q.push_back(32'(cyc + 1));
            end
            pend <= 1'b0;
         end else begin
            pend <= pend || load_req;
         end
      end
   end

   function automatic logic [63:0] exp_cd1(input int rw, input int s);
      logic [63:0] v = '0;
      if (s >= BL)
         for (int ch = 0; ch < CH; ch++)
            for (int c = 0; c < C; c++)
               if (sh[ch][rw][c] > s - BL) v[ch*C + C-1-c] = 1'b1;
      return v;
   endfunction

   // scoreboard: every cycle, both instances against the model
   always @(negedge clk) begin : monitor
      int t, p, rw, s, t2, p2, rw2, s2;
      logic exp_ack, fs1, fs2;
      if (!rst) begin
         t  = en_cnt / P;
         p  = t % F;
         rw = p / (BL + L);
         s  = p % (BL + L);
         fs1 = last_en && en_cnt > 0 && (en_cnt % (P * F) == 0);
         exp_ack = (exp_q.size() > 0) && (exp_q[0] == 32'(cyc));
         if (exp_ack) void'(exp_q.pop_front());
         check_eq("row_select", 64'(bus1.RowSelect), 64'(rw));
         check_eq("blank", 64'(bus1.Blank), 64'(s < BL));
         check_eq("col_drive", 64'(bus1.ColDrive), exp_cd1(rw, s));
         check_eq("frame_start", 64'(bus1.FrameStart), 64'(fs1));
         check_eq("load_ack", 64'(bus1.LoadAck), 64'(exp_ack));

         t2  = en_cnt / P2;
         p2  = t2 % F2;
         rw2 = p2 / (BL2 + L2);
         s2  = p2 % (BL2 + L2);
         fs2 = last_en && en_cnt > 0 && (en_cnt % (P2 * F2) == 0);
         check_eq("v2_row_select", 64'(bus2.RowSelect), 64'(rw2));
         check_eq("v2_blank", 64'(bus2.Blank), 64'(s2 < BL2));
         check_eq("v2_col_drive", 64'(bus2.ColDrive),
                  (t2 >= F2 && s2 >= BL2) ? 64'hFFF : 64'h0);
         check_eq("v2_frame_start", 64'(bus2.FrameStart), 64'(fs2));
         check_eq("v2_load_ack", 64'(bus2.LoadAck), 64'(fs2));
      end
   end

   initial begin
      int n, acks, en_cycles, total;
      logic [63:0] other_mask;
      int hi10, hi10_blank, hi30_row0, hi30_blank, hi31, others;

      foreach (pix[a, b, c]) pix[a][b][c] = 0;
      drive_pix();
      set_en(1'b0);
      set_req(1'b0);
      bus2.LoadReq = 1'b1;
      bus2.PixelIn = '1;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_row", 64'(bus1.RowSelect), 64'(0));
      check_eq("reset_blank", 64'(bus1.Blank), 64'(1));
      check_eq("reset_coldrive", 64'(bus1.ColDrive), 64'(0));
      check_eq("reset_pulses", 64'({bus1.FrameStart, bus1.LoadAck}), 64'(0));

      // reset pulse in the middle of row 5
      rst = 1'b0;
      set_en(1'b1);
      repeat (85) @(negedge clk);
      check_eq("row5_reached", 64'(bus1.RowSelect), 64'(5));
      rst = 1'b1;
      #1;
      check_eq("midrow_reset_row", 64'(bus1.RowSelect), 64'(0));
      check_eq("midrow_reset_blank", 64'(bus1.Blank), 64'(1));
      check_eq("midrow_reset_coldrive", 64'(bus1.ColDrive), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!bus1.FrameStart && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_eq("first_fs_latency", 64'(n), 64'(256));

      // single bright pixel plus the two intensity extremes
      pix[0][3][5] = 7;
      pix[1][0][0] = 0;
      pix[1][0][1] = L;
      drive_pix();
      repeat (20) @(negedge clk);
      set_req(1'b1);
      @(negedge clk);
      set_req(1'b0);
      n = 0;
      while (!bus1.LoadAck && n < 600) begin
         @(negedge clk);
         n++;
      end
      check_eq("ack_seen", 64'(bus1.LoadAck), 64'(1));
      check_eq("ack_with_frame_start", 64'(bus1.FrameStart), 64'(1));
      other_mask = ~((64'(1) << 10) | (64'(1) << 30));
      hi10 = 0; hi10_blank = 0; hi30_row0 = 0; hi30_blank = 0; hi31 = 0; others = 0;
      for (int i = 0; i < F; i++) begin
         if (bus1.ColDrive[10] && bus1.RowSelect == 3 && !bus1.Blank) hi10++;
         if (bus1.ColDrive[10] && bus1.Blank) hi10_blank++;
         if (bus1.ColDrive[30] && bus1.RowSelect == 0 && !bus1.Blank) hi30_row0++;
         if (bus1.ColDrive[30] && bus1.Blank) hi30_blank++;
         if (bus1.ColDrive[31]) hi31++;
         if ((64'(bus1.ColDrive) & other_mask) != 0) others++;
         @(negedge clk);
      end
      check_eq("bit10_on_cycles", 64'(hi10), 64'(7));
      check_eq("bit10_in_blank", 64'(hi10_blank), 64'(0));
      check_eq("bit30_on_cycles", 64'(hi30_row0), 64'(15));
      check_eq("bit30_in_blank", 64'(hi30_blank), 64'(0));
      check_eq("bit31_never", 64'(hi31), 64'(0));
      check_eq("other_bits_never", 64'(others), 64'(0));

      // new data without a request must not reach the display
      repeat (37) @(negedge clk);
      rand_pix();
      count_acks(3 * F, acks);
      check_eq("no_ack_without_req", 64'(acks), 64'(0));
      repeat (50) @(negedge clk);
      set_req(1'b1);
      @(negedge clk);
      set_req(1'b0);
      count_acks(2 * F, acks);
      check_eq("single_ack_after_req", 64'(acks), 64'(1));

      // freeze 100 cycles mid-ON: spacing counts enabled clocks only
      wait_fs("fs_before_freeze", 600);
      en_cycles = 0;
      total = 0;
      do begin
         set_en(!(total >= 40 && total < 140));
         if (en) en_cycles++;
         @(negedge clk);
         total++;
      end while (!bus1.FrameStart && total < 1000);
      set_en(1'b1);
      check_eq("fs_spacing_enabled", 64'(en_cycles), 64'(256));
      check_eq("fs_spacing_clocks", 64'(total), 64'(356));

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         set_en($urandom_range(0, 9) != 0);
         set_req($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 299) == 0) rand_pix();
         @(negedge clk);
      end
      set_req(1'b0);
      set_en(1'b1);
      repeat (F + 4) @(negedge clk);

      // request landing exactly in the wrap cycle
      n = 0;
      while ((en_cnt % F) != F - 1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      check_eq("wrap_cycle_reached", 64'(en_cnt % F), 64'(F - 1));
      rand_pix();
      set_req(1'b1);
      @(negedge clk);
      set_req(1'b0);
      check_eq("ack_at_wrap_req", 64'(bus1.LoadAck), 64'(1));
      @(negedge clk);
      count_acks(2 * F, acks);
      check_eq("wrap_req_no_repend", 64'(acks), 64'(0));

      #1;
      check_eq("ack_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
